// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-ported general-purpose register file for a
//               dual-issue core. NRD combinational read ports with same-cycle
//               write-to-read bypass, NWR posedge write ports with fixed
//               priority (higher port index = younger instruction wins), and
//               a per-register busy scoreboard used by decode to stall on
//               outstanding producers.
// Ports       :
//   clk       in   1            clock, all state updates on rising edge
//   reset     in   1            synchronous active-high reset
//   raddr     in   NRD*ADDR_W   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata     out  NRD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
//   rbusy     out  NRD          read source has an outstanding producer
//   wen       in   NWR          write enables
//   waddr     in   NWR*ADDR_W   write addresses
//   wdata     in   NWR*DATA_W   write data
//   set_en    in   NWR          issue slot marks its destination pending
//   set_addr  in   NWR*ADDR_W   destination register to mark pending
//   flush     in   1            clear every busy bit (pipeline squash)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR*ADDR_W-1:0]   waddr,
  input  logic [NWR*DATA_W-1:0]   wdata,
  input  logic [NWR-1:0]          set_en,
  input  logic [NWR*ADDR_W-1:0]   set_addr,
  input  logic                    flush
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic [NREGS-1:0]  w_set_vec;
  logic [NREGS-1:0]  w_clr_vec;
  logic [NREGS-1:0]  w_busy_next;

  // Register 0 is hard-wired when ZERO_REG is enabled.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // --------------------------------------------------------------------------
  // Register array write
  // Ports are visited in ascending order, so for colliding addresses the last
  // non-blocking assignment (highest index, youngest instruction) wins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && !is_zero_reg(waddr[j*ADDR_W +: ADDR_W])) begin
          r_regs[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard next state: flush > set > clear > hold.
  // A set and a write to the same register in one cycle leaves the bit set:
  // the write retires an older producer while the set belongs to a newer one.
  // --------------------------------------------------------------------------
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    for (int j = 0; j < NWR; j++) begin
      if (set_en[j]) begin
        w_set_vec[set_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
      if (wen[j]) begin
        w_clr_vec[waddr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      w_set_vec[0] = 1'b0;
    end
    if (flush) begin
      w_busy_next = '0;
    end else begin
      w_busy_next = w_set_vec | (r_busy & ~w_clr_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: bypass from the youngest matching write, otherwise the array.
  // A bypass hit also masks the busy bit, since the producer is completing
  // this very cycle.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit;
      logic [DATA_W-1:0] w_byp;

      assign w_ra = raddr[i*ADDR_W +: ADDR_W];

      always_comb begin
        w_hit = 1'b0;
        w_byp = '0;
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == w_ra)) begin
            w_hit = 1'b1;
            w_byp = wdata[j*DATA_W +: DATA_W];
          end
        end
      end

      assign rdata[i*DATA_W +: DATA_W] = is_zero_reg(w_ra) ? '0 :
                                         (w_hit ? w_byp : r_regs[w_ra]);
      assign rbusy[i] = r_busy[w_ra] & ~w_hit & ~is_zero_reg(w_ra);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Directed scenarios plus a
//               randomized phase, all compared against an array-based model
//               of register contents and busy flags.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRP = 4;
  localparam int NWP = 2;
  localparam int AW  = 5;

  logic               clk;
  logic               reset;
  logic [NRP*AW-1:0]  raddr;
  logic [NRP*DW-1:0]  rdata;
  logic [NRP-1:0]     rbusy;
  logic [NWP-1:0]     wen;
  logic [NWP*AW-1:0]  waddr;
  logic [NWP*DW-1:0]  wdata;
  logic [NWP-1:0]     set_en;
  logic [NWP*AW-1:0]  set_addr;
  logic               flush;

  // Stimulus kept per port, packed onto the buses below.
  logic [AW-1:0] t_raddr    [NRP];
  logic          t_wen      [NWP];
  logic [AW-1:0] t_waddr    [NWP];
  logic [DW-1:0] t_wdata    [NWP];
  logic          t_set_en   [NWP];
  logic [AW-1:0] t_set_addr [NWP];
  logic          t_reset;
  logic          t_flush;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(
    .DATA_W(DW), .NREGS(NR), .NRD(NRP), .NWR(NWP), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .set_en(set_en),
    .set_addr(set_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    raddr    = '0;
    wen      = '0;
    waddr    = '0;
    wdata    = '0;
    set_en   = '0;
    set_addr = '0;
    for (int i = 0; i < NRP; i++) raddr[i*AW +: AW] = t_raddr[i];
    for (int j = 0; j < NWP; j++) begin
      wen[j]                = t_wen[j];
      waddr[j*AW +: AW]     = t_waddr[j];
      wdata[j*DW +: DW]     = t_wdata[j];
      set_en[j]             = t_set_en[j];
      set_addr[j*AW +: AW]  = t_set_addr[j];
    end
    reset = t_reset;
    flush = t_flush;
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    for (int j = 0; j < NWP; j++)
      if (t_wen[j] && t_waddr[j] == a) v = t_wdata[j];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    for (int j = 0; j < NWP; j++)
      if (t_wen[j] && t_waddr[j] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    logic s, c;
    if (t_reset) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < NR; r++) begin
        s = 1'b0;
        c = 1'b0;
        for (int j = 0; j < NWP; j++) begin
          if (t_set_en[j] && t_set_addr[j] == AW'(r)) s = 1'b1;
          if (t_wen[j] && t_waddr[j] == AW'(r)) c = 1'b1;
        end
        if (t_flush)  m_busy[r] = 1'b0;
        else if (s)   m_busy[r] = 1'b1;
        else if (c)   m_busy[r] = 1'b0;
      end
      for (int j = 0; j < NWP; j++)
        if (t_wen[j] && t_waddr[j] != 0) m_regs[t_waddr[j]] = t_wdata[j];
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    for (int i = 0; i < NRP; i++) begin
      check($sformatf("%s rdata[%0d] r%0d", tag, i, t_raddr[i]),
            rdata[i*DW +: DW], exp_read(t_raddr[i]));
      check($sformatf("%s rbusy[%0d] r%0d", tag, i, t_raddr[i]),
            {31'd0, rbusy[i]}, {31'd0, exp_busy(t_raddr[i])});
    end
  endtask

  task automatic clear_ctl();
    t_reset = 1'b0;
    t_flush = 1'b0;
    for (int j = 0; j < NWP; j++) begin
      t_wen[j]    = 1'b0;
      t_set_en[j] = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step(input string tag, input bit chk);
    if (chk) begin
      #1;
      check_ports(tag);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    clear_ctl();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(1) == 1) return AW'($urandom_range(7));
    return AW'($urandom_range(NR - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clear_ctl();
    for (int i = 0; i < NRP; i++) t_raddr[i] = '0;
    for (int j = 0; j < NWP; j++) begin
      t_waddr[j] = '0; t_wdata[j] = '0; t_set_addr[j] = '0;
    end
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0; m_busy[r] = 1'b0;
    end
    @(negedge clk);

    // Reset with a concurrent write: the write must be ignored.
    t_reset = 1'b1;
    t_wen[0] = 1'b1; t_waddr[0] = 5'd5; t_wdata[0] = 32'hDEADBEEF;
    step("reset", 1'b0);
    for (int i = 0; i < NRP; i++) t_raddr[i] = 5'd5;
    #1;
    check("reset r5 data", rdata[0 +: DW], 32'h0);
    check("reset rbusy", {28'd0, rbusy}, 32'h0);
    step("post reset", 1'b1);

    // Dual write, same address: port 1 wins.
    t_wen[0] = 1'b1; t_waddr[0] = 5'd7; t_wdata[0] = 32'h11;
    t_wen[1] = 1'b1; t_waddr[1] = 5'd7; t_wdata[1] = 32'h22;
    t_raddr[0] = 5'd7;
    #1;
    check("dual bypass r7", rdata[0 +: DW], 32'h22);
    step("dual write", 1'b1);
    #1;
    check("dual array r7", rdata[0 +: DW], 32'h22);

    // Zero register ignores writes and sets.
    t_wen[1] = 1'b1; t_waddr[1] = 5'd0; t_wdata[1] = 32'hFFFF_FFFF;
    t_set_en[0] = 1'b1; t_set_addr[0] = 5'd0;
    t_raddr[0] = 5'd0;
    #1;
    check("zero during", rdata[0 +: DW], 32'h0);
    step("zero reg", 1'b1);
    #1;
    check("zero after", rdata[0 +: DW], 32'h0);
    check("zero busy", {31'd0, rbusy[0]}, 32'h0);

    // Scoreboard life cycle on r3.
    t_set_en[0] = 1'b1; t_set_addr[0] = 5'd3; t_raddr[0] = 5'd3;
    step("sb set", 1'b1);
    #1;
    check("sb busy r3", {31'd0, rbusy[0]}, 32'h1);
    step("sb wait", 1'b1);
    t_wen[0] = 1'b1; t_waddr[0] = 5'd3; t_wdata[0] = 32'hABCD;
    #1;
    check("sb bypass busy", {31'd0, rbusy[0]}, 32'h0);
    check("sb bypass data", rdata[0 +: DW], 32'hABCD);
    step("sb write", 1'b1);
    #1;
    check("sb cleared", {31'd0, rbusy[0]}, 32'h0);
    check("sb array data", rdata[0 +: DW], 32'hABCD);

    // Set/clear collision on r9.
    t_set_en[0] = 1'b1; t_set_addr[0] = 5'd9; t_raddr[0] = 5'd9;
    step("coll pre", 1'b1);
    t_wen[1] = 1'b1; t_waddr[1] = 5'd9; t_wdata[1] = 32'h55;
    t_set_en[0] = 1'b1; t_set_addr[0] = 5'd9;
    #1;
    check("coll busy same", {31'd0, rbusy[0]}, 32'h0);
    check("coll data same", rdata[0 +: DW], 32'h55);
    step("coll", 1'b1);
    #1;
    check("coll busy next", {31'd0, rbusy[0]}, 32'h1);

    // Flush beats a concurrent set.
    t_set_en[0] = 1'b1; t_set_addr[0] = 5'd4;
    t_set_en[1] = 1'b1; t_set_addr[1] = 5'd6;
    step("flush pre", 1'b1);
    t_raddr[0] = 5'd4; t_raddr[1] = 5'd6; t_raddr[2] = 5'd8;
    #1;
    check("flush pre r4", {31'd0, rbusy[0]}, 32'h1);
    check("flush pre r6", {31'd0, rbusy[1]}, 32'h1);
    t_flush = 1'b1;
    t_set_en[0] = 1'b1; t_set_addr[0] = 5'd8;
    step("flush", 1'b1);
    #1;
    check("flush r4", {31'd0, rbusy[0]}, 32'h0);
    check("flush r6", {31'd0, rbusy[1]}, 32'h0);
    check("flush r8", {31'd0, rbusy[2]}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      t_reset = ($urandom_range(63) == 0);
      t_flush = ($urandom_range(15) == 0);
      for (int j = 0; j < NWP; j++) begin
        t_wen[j]      = 1'($urandom_range(1));
        t_waddr[j]    = rand_addr();
        t_wdata[j]    = $urandom;
        t_set_en[j]   = 1'($urandom_range(1));
        t_set_addr[j] = rand_addr();
      end
      for (int i = 0; i < NRP; i++) t_raddr[i] = rand_addr();
      step("random", 1'b1);
    end

    // Reset in the middle of activity clears everything.
    t_reset = 1'b1; t_flush = 1'b1;
    for (int j = 0; j < NWP; j++) begin
      t_wen[j] = 1'b1; t_waddr[j] = AW'(j + 10); t_wdata[j] = 32'hCAFE0000;
      t_set_en[j] = 1'b1; t_set_addr[j] = AW'(j + 12);
    end
    step("midop reset", 1'b1);
    for (int g = 0; g < NR / NRP; g++) begin
      for (int i = 0; i < NRP; i++) t_raddr[i] = AW'(g * NRP + i);
      #1;
      check($sformatf("midop sweep data g%0d", g), rdata[0 +: DW] | rdata[DW +: DW] |
            rdata[2*DW +: DW] | rdata[3*DW +: DW], 32'h0);
      check($sformatf("midop sweep busy g%0d", g), {28'd0, rbusy}, 32'h0);
      step("midop sweep", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
